pll_clock_manager: RTL and testbench
====================================

Name: pll_clock_manager

Overview:
- Sits directly behind the board PLL primitive, in the PLL output clock domain.
- Qualifies the PLL lock, sequences a stretched synchronous system reset, and tracks lock-loss events.
- Generates CHANNELS independent fractional clock-enable strobes (phase accumulators), so slower subsystems (UART baud, timers, VGA) run from the single PLL clock without extra PLL outputs.

Parameters:
- CHANNELS, 2, number of clock-enable outputs (1..8)
- ACC_WIDTH, 16, phase accumulator width per channel
- LOCK_CYCLES, 1024, consecutive synchronised lock cycles required before reset sequencing (>=1)
- RESET_CYCLES, 16, cycles sysResetN stays low after lock qualification (>=1)
- LOSS_WIDTH, 8, width of the saturating lock-loss counter

Ports:
- clk  in  1  PLL output clock, sole clock of the block
- resetN  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- pllLock  in  1  raw PLL LOCK, asynchronous to clk
- swReset  in  1  synchronous request to re-run reset stretch, level, sampled each cycle
- clrLoss  in  1  synchronous clear of lockLost and lossCount
- incr  in  CHANNELS*ACC_WIDTH  per-channel phase increment, channel i at [i*ACC_WIDTH +: ACC_WIDTH]
- sysResetN  out  1  registered active-low system reset
- isReady  out  1  high exactly while state==RUN
- ce  out  CHANNELS  registered single-cycle enable strobes
- lockLost  out  1  sticky flag, set on lock loss in RUN
- lossCount  out  LOSS_WIDTH  saturating count of lock losses in RUN

Behaviour:
- Reset (resetN=0): state=WAIT_LOCK, sync FFs=0, counters=0, accumulators=0; sysResetN=0, isReady=0, ce=0, lockLost=0, lossCount=0.
- pllLock passes a 2-FF synchroniser -> lockSync (2-cycle latency). Only lockSync is used internally.
- States: WAIT_LOCK, QUALIFY, STRETCH, RUN. One shared counter, cleared on every state change.
- WAIT_LOCK: lockSync=1 -> QUALIFY.
- QUALIFY: lockSync=0 -> WAIT_LOCK. Otherwise, if counter==LOCK_CYCLES-1 -> STRETCH, else counter+1. QUALIFY lasts exactly LOCK_CYCLES cycles.
- STRETCH: lockSync=0 -> WAIT_LOCK. Otherwise, if counter==RESET_CYCLES-1 -> RUN, else counter+1.
- RUN: lockSync=0 -> WAIT_LOCK, with lockLost<=1 and lossCount+1 (saturating at all-ones). Else swReset=1 -> STRETCH, no loss counted.
- Priority in RUN: lock loss beats swReset. In any state, a loss event beats clrLoss in the same cycle: lossCount<=1, lockLost<=1.
- clrLoss alone: lockLost<=0, lossCount<=0, next cycle.
- sysResetN and isReady are registered from next-state==RUN: they rise on the edge that enters RUN and fall on the edge that leaves it. There are no glitches and no combinational path from pllLock.
- Phase accumulators:
  - Outside RUN: acc[i]<=0 and ce[i]<=0.
  - In RUN: {carry,acc[i]} <= acc[i] + incr[i] (ACC_WIDTH+1-bit add), and ce[i] <= carry.
  - Strobe rate is f_clk*incr/2^ACC_WIDTH. incr=0 gives no strobes. incr=2^ACC_WIDTH-1 gives strobes on all but one cycle in 2^ACC_WIDTH.
  - An incr change takes effect on the next edge; the accumulator is not reset.
- Asynchronous resetN assertion mid-operation forces all outputs to reset values immediately. Deassertion restarts from WAIT_LOCK.

Decomposition:
- Shared package clk_mgr_pkg: state encoding enum (WAIT_LOCK=0, QUALIFY=1, STRETCH=2, RUN=3) and the counter width function clog2(max(LOCK_CYCLES,RESET_CYCLES)).
- One sub-module, phase_ce_gen: a single accumulator channel (ports clk, resetN, run, incr, ce), instantiated CHANNELS times by generate.
- The sequencer FSM, synchroniser and loss counter stay in the top level.

Test Plan:
- Bench uses LOCK_CYCLES=8, RESET_CYCLES=4, ACC_WIDTH=4, CHANNELS=2.
- Lock-up: pllLock rises and edge 0 is the first edge sampling it high -> sysResetN and isReady rise at edge 14, and not earlier.
- Glitchy lock: pllLock high 5 cycles, low 1, then high -> QUALIFY aborts to WAIT_LOCK and restarts; sysResetN rises 14 edges after the final rise; lossCount stays 0.
- Fractional enables: in RUN with incr0=4, incr1=8 -> ce[0] pulses every 4th cycle, first pulse on the 4th edge after RUN entry; ce[1] pulses on alternate cycles; incr0=0 -> ce[0] stays 0.
- Lock loss: drop pllLock in RUN -> sysResetN falls 3 edges later (2 sync + 1), ce cleared, lockLost=1, lossCount=1. After 300 losses lossCount=255 (saturated).
- swReset in RUN -> sysResetN low for exactly 4 cycles, then high; lossCount unchanged. swReset together with lock loss -> WAIT_LOCK and lossCount increments.
- clrLoss: in the same cycle as a loss -> lossCount=1. clrLoss alone -> lossCount=0, lockLost=0. resetN pulse mid-STRETCH -> all outputs 0 immediately.

Source files
------------

// File: rtl/clk_mgr_pkg.sv
// Shared definitions for the PLL clock manager: sequencer state encoding and
// the width of the shared qualify/stretch counter.
package clk_mgr_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        STRETCH   = 2'd2,
        RUN       = 2'd3
    } mgr_state_t;

    // One counter serves both QUALIFY and STRETCH, so size it for the longer one.
    function automatic int cnt_width(input int lock_cycles, input int reset_cycles);
        int longest;
        longest = (lock_cycles > reset_cycles) ? lock_cycles : reset_cycles;
        return (longest <= 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/phase_ce_gen.sv
// One fractional clock-enable channel: a phase accumulator whose carry-out
// becomes a registered single-cycle enable strobe.
module phase_ce_gen
    import clk_mgr_pkg::*;
#(
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 run,
    input  logic [ACC_WIDTH-1:0] incr,
    output logic                 ce
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, incr};

    // The accumulator is only live while the system runs, so every RUN entry
    // starts from phase zero and the strobe spacing is deterministic.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (run) begin
            acc <= sum[ACC_WIDTH-1:0];
            ce  <= sum[ACC_WIDTH];
        end else begin
            acc <= '0;
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/pll_clock_manager.sv
// PLL lock qualification, stretched system reset sequencing, lock-loss
// tracking and a bank of fractional clock-enable generators.
module pll_clock_manager
    import clk_mgr_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int ACC_WIDTH    = 16,
    parameter int LOCK_CYCLES  = 1024,
    parameter int RESET_CYCLES = 16,
    parameter int LOSS_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          pllLock,
    input  logic                          swReset,
    input  logic                          clrLoss,
    input  logic [CHANNELS*ACC_WIDTH-1:0] incr,
    output logic                          sysResetN,
    output logic                          isReady,
    output logic [CHANNELS-1:0]           ce,
    output logic                          lockLost,
    output logic [LOSS_WIDTH-1:0]         lossCount
);

    localparam int CNT_W = cnt_width(LOCK_CYCLES, RESET_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(RESET_CYCLES - 1);

    mgr_state_t     state;
    logic [CNT_W-1:0] count;
    logic           lock_meta;
    logic           lock_sync;
    logic           in_run;
    logic           loss_event;

    // pllLock is asynchronous to clk; nothing but lock_sync may look at it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pllLock;
            lock_sync <= lock_meta;
        end
    end

    // sysResetN and isReady are set on the very transitions into and out of
    // RUN, which makes them registered copies of "next state is RUN".
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= WAIT_LOCK;
            count     <= '0;
            sysResetN <= 1'b0;
            isReady   <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_sync) begin
                        state <= QUALIFY;
                        count <= '0;
                    end
                end
                QUALIFY: begin
                    if (!lock_sync) begin
                        state <= WAIT_LOCK;
                        count <= '0;
                    end else if (count == LOCK_LAST) begin
                        state <= STRETCH;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                STRETCH: begin
                    if (!lock_sync) begin
                        state <= WAIT_LOCK;
                        count <= '0;
                    end else if (count == STRETCH_LAST) begin
                        state     <= RUN;
                        count     <= '0;
                        sysResetN <= 1'b1;
                        isReady   <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_sync) begin
                        state     <= WAIT_LOCK;
                        count     <= '0;
                        sysResetN <= 1'b0;
                        isReady   <= 1'b0;
                    end else if (swReset) begin
                        state     <= STRETCH;
                        count     <= '0;
                        sysResetN <= 1'b0;
                        isReady   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_run     = (state == RUN);
    assign loss_event = in_run && !lock_sync;

    // A loss in the same cycle as a clear wins: the clear is applied first,
    // then this loss is counted on top of it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lockLost  <= 1'b0;
            lossCount <= '0;
        end else if (loss_event) begin
            lockLost <= 1'b1;
            if (clrLoss) begin
                lossCount <= LOSS_WIDTH'(1);
            end else if (lossCount != '1) begin
                lossCount <= lossCount + 1'b1;
            end
        end else if (clrLoss) begin
            lockLost  <= 1'b0;
            lossCount <= '0;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        phase_ce_gen #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_ce (
            .clk    (clk),
            .resetN (resetN),
            .run    (in_run),
            .incr   (incr[i*ACC_WIDTH +: ACC_WIDTH]),
            .ce     (ce[i])
        );
    end

endmodule

// File: tb/tb_pll_clock_manager.sv
// Self-checking bench for pll_clock_manager: directed vector table, hand-written
// corner sequences and randomized traffic against a lock-streak reference model.
module tb_pll_clock_manager;

    localparam int CH = 2;
    localparam int AW = 4;
    localparam int LC = 8;
    localparam int RC = 4;
    localparam int LW = 8;
    localparam int CNT_MAX = (1 << LW) - 1;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            pllLock = 1'b0;
    logic            swReset = 1'b0;
    logic            clrLoss = 1'b0;
    logic [CH*AW-1:0] incr = '0;
    logic            sysResetN;
    logic            isReady;
    logic [CH-1:0]   ce;
    logic            lockLost;
    logic [LW-1:0]   lossCount;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pll_clock_manager #(
        .CHANNELS     (CH),
        .ACC_WIDTH    (AW),
        .LOCK_CYCLES  (LC),
        .RESET_CYCLES (RC),
        .LOSS_WIDTH   (LW)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .pllLock   (pllLock),
        .swReset   (swReset),
        .clrLoss   (clrLoss),
        .incr      (incr),
        .sysResetN (sysResetN),
        .isReady   (isReady),
        .ce        (ce),
        .lockLost  (lockLost),
        .lossCount (lossCount)
    );

    // Reference model: the system runs once the synchronised lock has been seen
    // high on LC+RC+1 consecutive edges; a software reset rewinds that streak
    // to the point where only the RC stretch edges remain.
    bit mS1, mS2, mRunning, mLost;
    int mGood, mCount;
    int mAcc[CH];
    bit mCe[CH];

    task automatic modelReset();
        mS1 = 0; mS2 = 0; mRunning = 0; mLost = 0; mGood = 0; mCount = 0;
        for (int i = 0; i < CH; i++) begin
            mAcc[i] = 0;
            mCe[i]  = 0;
        end
    endtask

    task automatic modelEdge();
        bit ls;
        bit wasRun;
        bit loss;
        ls = mS2;
        wasRun = mRunning;
        loss = wasRun && !ls;
        for (int i = 0; i < CH; i++) begin
            int sum;
            sum = mAcc[i] + int'(incr[i*AW +: AW]);
            if (wasRun) begin
                mCe[i]  = (sum >= (1 << AW));
                mAcc[i] = sum % (1 << AW);
            end else begin
                mCe[i]  = 0;
                mAcc[i] = 0;
            end
        end
        if (!ls) mGood = 0;
        else if (wasRun && swReset) mGood = LC + 1;
        else if (mGood < 1000) mGood++;
        mRunning = (mGood >= LC + RC + 1);
        if (loss) begin
            mLost = 1;
            mCount = clrLoss ? 1 : ((mCount < CNT_MAX) ? mCount + 1 : CNT_MAX);
        end else if (clrLoss) begin
            mLost = 0;
            mCount = 0;
        end
        mS2 = mS1;
        mS1 = pllLock;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic checkModel();
        logic [CH-1:0] ec;
        for (int i = 0; i < CH; i++) ec[i] = mCe[i];
        checkOutput("model sysResetN", int'(sysResetN), int'(mRunning));
        checkOutput("model isReady", int'(isReady), int'(mRunning));
        checkOutput("model ce", int'(ce), int'(ec));
        checkOutput("model lockLost", int'(lockLost), int'(mLost));
        checkOutput("model lossCount", int'(lossCount), mCount);
    endtask

    task automatic applyStimulus(input bit lk, input bit sw, input bit clr, input logic [CH*AW-1:0] inc);
        pllLock = lk;
        swReset = sw;
        clrLoss = clr;
        incr    = inc;
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
    endtask

    task automatic doReset();
        resetN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        modelReset();
        #1;
        checkModel();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Raises the lock and reports the edge index (0 = first edge sampling it
    // high) on which the system becomes ready, or -1 if it never does.
    task automatic lockUp(output int idx);
        pllLock = 1'b1;
        idx = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (isReady) begin
                idx = k;
                break;
            end
        end
    endtask

    typedef struct {
        bit            lock;
        bit            sw;
        bit            clr;
        logic [CH*AW-1:0] inc;
        int            cycles;
        bit            expReady;
        bit            expLost;
        int            expCount;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int idx;
        int firstCe0, firstCe1, pulses0, pulses1, lows;

        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00,  5, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 14, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00,  1, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00,  2, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00,  1, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00,  1, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 13, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00,  1, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00,  1, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00,  3, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00,  1, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h84, 20, 1'b1, 1'b0, 0});

        doReset();
        foreach (vecs[v]) begin
            applyStimulus(vecs[v].lock, vecs[v].sw, vecs[v].clr, vecs[v].inc);
            for (int c = 0; c < vecs[v].cycles; c++) step();
            checkOutput($sformatf("vec%0d isReady", v), int'(isReady), int'(vecs[v].expReady));
            checkOutput($sformatf("vec%0d lockLost", v), int'(lockLost), int'(vecs[v].expLost));
            checkOutput($sformatf("vec%0d lossCount", v), int'(lossCount), vecs[v].expCount);
        end

        // Fractional enables from RUN entry, then a channel switched off
        doReset();
        incr = 8'h84;
        lockUp(idx);
        checkOutput("lockup edge", idx, 14);
        firstCe0 = -1;
        firstCe1 = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ce[0] && firstCe0 < 0) firstCe0 = k;
            if (ce[1] && firstCe1 < 0) firstCe1 = k;
        end
        checkOutput("first ce0 edge", firstCe0, 4);
        checkOutput("first ce1 edge", firstCe1, 2);
        pulses0 = 0;
        pulses1 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            pulses0 += int'(ce[0]);
            pulses1 += int'(ce[1]);
        end
        checkOutput("ce0 pulses per 16", pulses0, 4);
        checkOutput("ce1 pulses per 16", pulses1, 8);
        incr = 8'h80;
        pulses0 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            pulses0 += int'(ce[0]);
        end
        checkOutput("ce0 pulses incr0=0", pulses0, 0);

        // Lock loss latency and cleanup
        pllLock = 1'b0;
        lows = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (!sysResetN) begin
                lows = k;
                break;
            end
        end
        checkOutput("loss latency edges", lows, 3);
        checkOutput("loss lockLost", int'(lockLost), 1);
        checkOutput("loss lossCount", int'(lossCount), 1);
        step();
        checkOutput("ce after loss", int'(ce), 0);

        // Glitchy lock restarts qualification
        doReset();
        pllLock = 1'b1;
        repeat (5) step();
        pllLock = 1'b0;
        step();
        lockUp(idx);
        checkOutput("glitch lockup edge", idx, 14);
        checkOutput("glitch lossCount", int'(lossCount), 0);

        // Software reset stretch
        swReset = 1'b1;
        step();
        swReset = 1'b0;
        lows = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (sysResetN) break;
            lows++;
        end
        checkOutput("swReset low cycles", lows, 4);
        checkOutput("swReset lossCount", int'(lossCount), 0);

        // swReset coinciding with a loss: the loss wins
        pllLock = 1'b0;
        step();
        step();
        swReset = 1'b1;
        step();
        swReset = 1'b0;
        checkOutput("sw+loss sysResetN", int'(sysResetN), 0);
        checkOutput("sw+loss lossCount", int'(lossCount), 1);
        repeat (5) step();
        checkOutput("sw+loss stays down", int'(isReady), 0);

        // clrLoss with a loss, then alone
        lockUp(idx);
        pllLock = 1'b0;
        step();
        step();
        clrLoss = 1'b1;
        step();
        clrLoss = 1'b0;
        checkOutput("clr+loss lossCount", int'(lossCount), 1);
        checkOutput("clr+loss lockLost", int'(lockLost), 1);
        clrLoss = 1'b1;
        step();
        clrLoss = 1'b0;
        checkOutput("clr lossCount", int'(lossCount), 0);
        checkOutput("clr lockLost", int'(lockLost), 0);

        // Saturation after 300 losses
        for (int n = 0; n < 300; n++) begin
            lockUp(idx);
            pllLock = 1'b0;
            repeat (3) step();
        end
        checkOutput("saturated lossCount", int'(lossCount), 255);

        // Asynchronous reset in the middle of STRETCH
        pllLock = 1'b1;
        repeat (12) step();
        resetN = 1'b0;
        #1;
        checkOutput("async sysResetN", int'(sysResetN), 0);
        checkOutput("async isReady", int'(isReady), 0);
        checkOutput("async ce", int'(ce), 0);
        checkOutput("async lockLost", int'(lockLost), 0);
        checkOutput("async lossCount", int'(lossCount), 0);
        doReset();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            pllLock = ($urandom_range(0, 63) != 0);
            swReset = ($urandom_range(0, 31) == 0);
            clrLoss = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) incr = CH*AW'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
